// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory store unit.
package dmem_pkg;

   localparam int V     = 192;
   localparam int SIZE  = 150000;
   localparam int AW    = 18;
   localparam int LANES = V / 8;
   localparam int DEPTH = 4;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;
   localparam int EW    = 1 + AW + V;

   localparam logic [AW-1:0] SIZE_A = AW'(SIZE);

   typedef struct packed {
      logic          vec;
      logic [AW-1:0] addr;
      logic [V-1:0]  data;
   } store_entry_t;

   typedef enum logic {RUN, FLUSH} flush_state_e;

   function automatic logic in_range(input logic [AW-1:0] a);
      return a < SIZE_A;
   endfunction

endpackage

// File: rtl/dmem_store_fifo.sv
// Generic DEPTH-entry synchronous FIFO; with DMEM_STORE_FWD_EN it also exposes
// its storage and read pointer so the owner can search pending entries.
module dmem_store_fifo #(
   parameter  int W     = 8,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  data_i,
   output logic [W-1:0]  data_o,
   output logic          full_o,
   output logic          empty_o,
`ifdef DMEM_STORE_FWD_EN
   output logic [W-1:0]  mem_o [DEPTH],
   output logic [PW-1:0] rd_ptr_o,
`endif
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

`ifdef DMEM_STORE_FWD_EN
   assign mem_o    = mem_q;
   assign rd_ptr_o = rd_ptr_q;
`endif

   // NOTE: storage is left unreset on purpose; only the pointers and count
   // define which entries are valid, so clearing the array buys nothing.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/dmem_store_unit.sv
// Store FIFO + byte-enabled result RAM with a registered read port and flush
// handshake. Define DMEM_STORE_FWD_EN to let reads see pending FIFO stores.
module dmem_store_unit
   import dmem_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          VecOp,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [AW-1:0] address,
   input  logic [V-1:0]  wd,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_address,
   output logic [V-1:0]  rd,
   output logic          rd_valid,
   input  logic          flush_req,
   output logic          flush_done,
   output logic          err_oor,
   output logic [CW-1:0] fifo_count
);

   store_entry_t push_entry, head;
   logic         full, empty, push, pop;
   logic [LANES-1:0] be;
   logic [V-1:0] ram [SIZE];
   logic [V-1:0] rd_d, rd_q;
   logic         rd_valid_q, flush_done_q, flush_done_d, err_oor_q;
   flush_state_e state_q, state_d;

   assign wr_ready   = (state_q == RUN) && !full;
   assign push       = wr_valid && wr_ready;
   assign pop        = !empty;
   assign push_entry = '{vec: VecOp, addr: address, data: wd};
   assign be         = head.vec ? '1 : LANES'(1);

`ifdef DMEM_STORE_FWD_EN
   logic [EW-1:0] fifo_mem [DEPTH];
   logic [PW-1:0] fifo_rd_ptr, fwd_idx;
   store_entry_t  fwd_e;
`endif

   dmem_store_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_i   (push),
      .pop_i    (pop),
      .data_i   (push_entry),
      .data_o   (head),
      .full_o   (full),
      .empty_o  (empty),
`ifdef DMEM_STORE_FWD_EN
      .mem_o    (fifo_mem),
      .rd_ptr_o (fifo_rd_ptr),
`endif
      .count_o  (fifo_count)
   );

   // Head commits every cycle the FIFO is non-empty; out-of-range writes are dropped.
   always_ff @(posedge clk) begin
      if (pop && in_range(head.addr)) begin
         for (int l = 0; l < LANES; l++) begin
            if (be[l]) ram[head.addr][l*8 +: 8] <= head.data[l*8 +: 8];
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      rd_d = '0;
      if (in_range(rd_address)) rd_d = ram[rd_address];
`ifdef DMEM_STORE_FWD_EN
      fwd_idx = '0;
      fwd_e   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = fifo_rd_ptr + PW'(i);
         fwd_e   = fifo_mem[fwd_idx];
         if (CW'(i) < fifo_count && fwd_e.addr == rd_address && in_range(rd_address)) begin
            if (fwd_e.vec) rd_d      = fwd_e.data;
            else           rd_d[7:0] = fwd_e.data[7:0];
         end
      end
`endif
   end

   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      case (state_q)
         RUN: begin
            if (flush_req) begin
               if (fifo_count == '0) flush_done_d = 1'b1;
               else                  state_d      = FLUSH;
            end
         end
         FLUSH: begin
            // No pushes here, so the FIFO empties at this edge when count <= 1.
            if (fifo_count <= CW'(1)) begin
               flush_done_d = 1'b1;
               state_d      = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         flush_done_q <= 1'b0;
         rd_q         <= '0;
         rd_valid_q   <= 1'b0;
         err_oor_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_done_q <= flush_done_d;
         rd_valid_q   <= rd_en;
         if (rd_en) rd_q <= rd_d;
         if (pop && !in_range(head.addr)) err_oor_q <= 1'b1;
      end
   end

   assign rd         = rd_q;
   assign rd_valid   = rd_valid_q;
   assign flush_done = flush_done_q;
   assign err_oor    = err_oor_q;

endmodule
